// File: rtl/multi_stage_pipeline_reg.sv
// multi_stage_pipeline_reg: DEPTH-stage valid/ready register pipeline with flush.
// Optional input skid buffer (registered in_ready) under MULTI_STAGE_PIPE_SKID_EN.
module multi_stage_pipeline_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             in_fire;
  logic             out_fire;

  // a stage can load if it or any stage below it is empty, or the sink takes
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v[j]) rdy[i] = 1'b1;
      end
    end
  end

  // each stage is fed by the stage before it; stage 0 by the input side
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      up_v[i] = 1'b0;
      up_d[i] = '0;
    end
    up_v[0] = src_v;
    up_d[0] = src_d;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

`ifdef MULTI_STAGE_PIPE_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;

  assign in_ready = !skid_v;
  assign src_v    = skid_v || in_valid;
  assign src_d    = skid_v ? skid_d : in_data;

  // skid catches a word stage 0 cannot take, drains first when it can
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (flush) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (rdy[0]) skid_v <= 1'b0;
    end else if (in_valid && !rdy[0]) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
`else
  assign in_ready = rdy[0];
  assign src_v    = in_valid;
  assign src_d    = in_data;
`endif

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = v[DEPTH-1] && out_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // advance every ready stage; flush drops all valids but leaves data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_v[i]) d[i] <= up_d[i];
      end
      if (flush) begin
        v <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rdy[i]) v[i] <= up_v[i];
        end
      end
    end
  end

  // held-word count, net of this edge's input and output transfers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_stage_pipeline_reg.sv
// tb_multi_stage_pipeline_reg: directed checks of multi_stage_pipeline_reg.
// Capacity follows MULTI_STAGE_PIPE_SKID_EN when the bench is built with it.
module tb_multi_stage_pipeline_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 2);
`ifdef MULTI_STAGE_PIPE_SKID_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  int checks;
  int failures;

  logic [WIDTH-1:0] q [$];
  logic             ifire;
  logic             ofire;
  logic [WIDTH-1:0] front;

  multi_stage_pipeline_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    reset = 1'b0;

    // single word latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_BBBB;
    #1;
    chk("single_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      chk("single_valid", 64'(out_valid), 64'(e == DEPTH - 1));
      chk("single_occ", 64'(occupancy), 64'd1);
      if (e == DEPTH - 1)
        chk("single_data", 64'(out_data), 64'hAAAA_BBBB);
      if (e != DEPTH - 1) tick();
    end
    tick();
    chk("single_gone", 64'(out_valid), 64'd0);
    chk("single_occ0", 64'(occupancy), 64'd0);

    // streaming 16 words back to back
    for (int c = 0; c < 16 + DEPTH; c++) begin
      in_valid = (c < 16);
      in_data  = 32'(c + 1);
      #1;
      if (c < 16) chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid),
          64'((c >= DEPTH - 1) && (c - (DEPTH - 1) < 16)));
      if ((c >= DEPTH - 1) && (c - (DEPTH - 1) < 16))
        chk("stream_data", 64'(out_data), 64'(c - (DEPTH - 1) + 1));
    end
    in_valid = 1'b0;
    chk("stream_occ0", 64'(occupancy), 64'd0);

    // backpressure fill to capacity
    out_ready = 1'b0;
    for (int j = 0; j < CAP; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5678 + 32'(j);
      #1;
      chk("bp_fill_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_data = 32'h0BAD_0BAD;
    #1;
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_occ", 64'(occupancy), 64'(CAP));
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'h1234_5678);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    for (int j = 0; j < CAP; j++) begin
      #1;
      chk("bp_drain_valid", 64'(out_valid), 64'd1);
      chk("bp_drain_data", 64'(out_data), 64'(32'h1234_5678 + 32'(j)));
      tick();
    end
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_occ", 64'(occupancy), 64'd0);

    // flush with 3 words held and 0xDEAD offered
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(j);
      tick();
    end
    chk("fl_pre_occ", 64'(occupancy), 64'd3);
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      tick();
      chk("fl_no_dead", 64'(out_valid), 64'd0);
    end

    // reset between edges while full and stalled
    out_ready = 1'b0;
    for (int j = 0; j < CAP; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + 32'(j);
      tick();
    end
    in_valid = 1'b0;
    chk("rs_pre_occ", 64'(occupancy), 64'(CAP));
    #2;
    reset = 1'b1;
    #1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_occ", 64'(occupancy), 64'd0);
    chk("rs_data", 64'(out_data), 64'd0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    in_valid = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      chk("rs_lat_valid", 64'(out_valid), 64'(e == DEPTH - 1));
      if (e == DEPTH - 1)
        chk("rs_lat_data", 64'(out_data), 64'h5);
      if (e != DEPTH - 1) tick();
    end
    tick();
    chk("rs_done_occ", 64'(occupancy), 64'd0);

    // random valid/ready against an ordering scoreboard
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire) begin
        checks++;
        assert (q.size() > 0)
        else begin
          failures++;
          $error("FAIL rnd_spurious observed=%0h expected=none", out_data);
        end
        if (q.size() > 0) begin
          front = q.pop_front();
          chk("rnd_data", 64'(out_data), 64'(front));
        end
      end
      if (ifire) q.push_back(in_data);
      tick();
      chk("rnd_occ", 64'(occupancy), 64'(q.size()));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < CAP + DEPTH + 2; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        assert (q.size() > 0)
        else begin
          failures++;
          $error("FAIL rnd_tail_spurious observed=%0h expected=none",
                 out_data);
        end
        if (q.size() > 0) begin
          front = q.pop_front();
          chk("rnd_tail_data", 64'(out_data), 64'(front));
        end
      end
      tick();
    end
    chk("rnd_left", 64'(q.size()), 64'd0);
    chk("rnd_end_occ", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
